// File: rtl/m_simsram_wb_if.sv
// Wishbone classic slave bundle for the simulated SRAM.
// The error-check build option SIMSRAM_ERRCHK_EN adds the ERR_O line.
// Parameters must match those of the m_simsram_wb instance it connects to.
interface m_simsram_wb_if #(
  parameter int SRAMADRWIDTH = 16,
  parameter int DATAWIDTH    = 32
);
  logic                      CYC_I;
  logic                      STB_I;
  logic                      WE_I;
  logic [SRAMADRWIDTH-1:0]   ADR_I;
  logic [DATAWIDTH/8-1:0]    SEL_I;
  logic [DATAWIDTH-1:0]      DAT_I;
  logic [DATAWIDTH-1:0]      DAT_O;
  logic                      ACK_O;
`ifdef SIMSRAM_ERRCHK_EN
  logic                      ERR_O;
`endif

  // Bus master side: drives the request, observes the response.
  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
`ifdef SIMSRAM_ERRCHK_EN
    input  ERR_O,
`endif
    input  DAT_O, ACK_O
  );

  // SRAM side: observes the request, drives the response.
  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
`ifdef SIMSRAM_ERRCHK_EN
    output ERR_O,
`endif
    output DAT_O, ACK_O
  );
endinterface

// File: rtl/m_simsram_wb.sv
// m_simsram_wb: simulated SRAM behind a Wishbone classic slave port.
// Every access is captured in IDLE, waits WAITSTATES cycles, then completes
// in DONE; the acknowledge (and read data) appear on the edge that leaves
// DONE, so ACK follows the request edge by WAITSTATES+1 cycles.
// Build option SIMSRAM_ERRCHK_EN: accesses beyond SRAMDEPTH or with no byte
// lane selected complete with ERR_O instead of ACK_O and have no effect.
// Without it, such writes are silently dropped and out-of-range reads give 0.
// DATAWIDTH is expected to be 16 or 32; WAITSTATES 0..15.
module m_simsram_wb #(
  parameter int SRAMADRWIDTH = 16,
  parameter int SRAMDEPTH    = 2**SRAMADRWIDTH,
  parameter int DATAWIDTH    = 32,
  parameter int WAITSTATES   = 1
) (
  input logic           CLK_I,
  input logic           RST_I,
  m_simsram_wb_if.slave wb
);

  localparam int NLANES   = DATAWIDTH / 8;
  localparam int IDXWIDTH = (SRAMDEPTH > 1) ? $clog2(SRAMDEPTH) : 1;

  // Depth expressed one bit wider than the address so 2**SRAMADRWIDTH fits.
  localparam logic [SRAMADRWIDTH:0] DEPTHLIMIT = (SRAMADRWIDTH+1)'(SRAMDEPTH);
  localparam logic [3:0]            WAITLOAD   = 4'(WAITSTATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [3:0]              waitCnt_q;
  logic [3:0]              waitCnt_d;
  logic                    accept;

  logic [SRAMADRWIDTH-1:0] reqAdr_q;
  logic                    reqWe_q;
  logic [NLANES-1:0]       reqSel_q;
  logic [DATAWIDTH-1:0]    reqDat_q;

  logic [DATAWIDTH-1:0]    mem [SRAMDEPTH];
  logic [IDXWIDTH-1:0]     memIdx;
  logic                    inRange;
  logic                    finish;
  logic                    memWrite;

  logic                    ack_q;
  logic                    ack_d;
  logic [DATAWIDTH-1:0]    datOut_q;
  logic [DATAWIDTH-1:0]    datOut_d;
`ifdef SIMSRAM_ERRCHK_EN
  logic                    err_q;
  logic                    err_d;
  logic                    badAccess;
`endif

  // State and wait counter; reset abandons any access in flight.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q   <= IDLE;
      waitCnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Next state: accept in IDLE, count down in WAIT, always leave DONE;
  // losing CYC_I while waiting drops the access.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wb.CYC_I && wb.STB_I) begin
          accept    = 1'b1;
          waitCnt_d = WAITLOAD;
          state_d   = (WAITSTATES == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (!wb.CYC_I) begin
          state_d   = IDLE;
          waitCnt_d = 4'd0;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
          if (waitCnt_q <= 4'd1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        waitCnt_d = 4'd0;
      end
      default: begin
        state_d   = IDLE;
        waitCnt_d = 4'd0;
      end
    endcase
  end

  // Completion decode: what the edge leaving DONE does to memory and outputs.
  always_comb begin
    finish   = (state_q == DONE) && wb.CYC_I;
    inRange  = ({1'b0, reqAdr_q} < DEPTHLIMIT);
    memIdx   = reqAdr_q[IDXWIDTH-1:0];
    datOut_d = datOut_q;
`ifdef SIMSRAM_ERRCHK_EN
    badAccess = !inRange || (reqSel_q == '0);
    memWrite  = finish && reqWe_q && !badAccess;
    ack_d     = finish && !badAccess;
    err_d     = finish && badAccess;
    if (finish && !reqWe_q && !badAccess) begin
      datOut_d = mem[memIdx];
    end
`else
    memWrite = finish && reqWe_q && inRange;
    ack_d    = finish;
    if (finish && !reqWe_q) begin
      datOut_d = inRange ? mem[memIdx] : '0;
    end
`endif
  end

  // Capture the request so the bus may change while the access is pending.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      reqAdr_q <= '0;
      reqWe_q  <= 1'b0;
      reqSel_q <= '0;
      reqDat_q <= '0;
    end else if (accept) begin
      reqAdr_q <= wb.ADR_I;
      reqWe_q  <= wb.WE_I;
      reqSel_q <= wb.SEL_I;
      reqDat_q <= wb.DAT_I;
    end
  end

  // Registered responses; DAT_O only moves on a successful read completion.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ack_q    <= 1'b0;
      datOut_q <= '0;
`ifdef SIMSRAM_ERRCHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      ack_q    <= ack_d;
      datOut_q <= datOut_d;
`ifdef SIMSRAM_ERRCHK_EN
      err_q    <= err_d;
`endif
    end
  end

  // Byte-lane write into the array; contents deliberately survive reset.
  always_ff @(posedge CLK_I) begin
    if (memWrite) begin
      for (int b = 0; b < NLANES; b++) begin
        if (reqSel_q[b]) begin
          mem[memIdx][8*b +: 8] <= reqDat_q[8*b +: 8];
        end
      end
    end
  end

  assign wb.ACK_O = ack_q;
  assign wb.DAT_O = datOut_q;
`ifdef SIMSRAM_ERRCHK_EN
  assign wb.ERR_O = err_q;
`endif

endmodule

// File: tb/tb_m_simsram_wb.sv
// Bench for m_simsram_wb: a 1-wait-state, 256-word instance driven from a
// vector table, hand sequences and random traffic checked against a simple
// memory model, plus a 3-wait-state instance for back-to-back timing.
// Honours SIMSRAM_ERRCHK_EN when the design is built with it.
module tb_m_simsram_wb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef SIMSRAM_ERRCHK_EN
  localparam bit ERRMODE = 1'b1;
`else
  localparam bit ERRMODE = 1'b0;
`endif

  m_simsram_wb_if #(.SRAMADRWIDTH(16), .DATAWIDTH(32)) busA ();
  m_simsram_wb_if #(.SRAMADRWIDTH(8),  .DATAWIDTH(32)) busB ();

  m_simsram_wb #(
    .SRAMADRWIDTH(16), .SRAMDEPTH(256), .DATAWIDTH(32), .WAITSTATES(1)
  ) dutA (
    .CLK_I(clk), .RST_I(rst), .wb(busA)
  );

  m_simsram_wb #(
    .SRAMADRWIDTH(8), .SRAMDEPTH(256), .DATAWIDTH(32), .WAITSTATES(3)
  ) dutB (
    .CLK_I(clk), .RST_I(rst), .wb(busB)
  );

  logic errA;
`ifdef SIMSRAM_ERRCHK_EN
  assign errA = busA.ERR_O;
`else
  assign errA = 1'b0;
`endif

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: plain word array plus the value DAT_O should hold.
  logic [31:0] refMem [256];
  logic [31:0] refDat;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        expAck;
    logic        expErr;
    logic [31:0] expDat;
  } vec_t;

  vec_t vecs [16];

  int   lat;
  logic gotAck;
  logic gotErr;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic isErr(input logic [15:0] adr, input logic [3:0] sel);
    return ERRMODE && ((adr >= 16'd256) || (sel == 4'd0));
  endfunction

  // Model of one completed access, straight from the access rules.
  function automatic void modelApply(input logic we, input logic [15:0] adr,
                                     input logic [3:0] sel, input logic [31:0] dat);
    if (isErr(adr, sel)) return;
    if (we) begin
      if (adr < 16'd256) begin
        for (int b = 0; b < 4; b++) begin
          if (sel[b]) refMem[adr[7:0]][8*b +: 8] = dat[8*b +: 8];
        end
      end
    end else begin
      refDat = (adr < 16'd256) ? refMem[adr[7:0]] : 32'd0;
    end
  endfunction

  // One access on dutA; returns edges from request to response (-1 on timeout).
  task automatic applyStimulus(input logic we, input logic [15:0] adr,
                               input logic [3:0] sel, input logic [31:0] dat,
                               output int l, output logic a, output logic e);
    busA.CYC_I = 1'b1;
    busA.STB_I = 1'b1;
    busA.WE_I  = we;
    busA.ADR_I = adr;
    busA.SEL_I = sel;
    busA.DAT_I = dat;
    @(posedge clk); #1;
    l = -1;
    a = 1'b0;
    e = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (busA.ACK_O || errA) begin
        l = n;
        a = busA.ACK_O;
        e = errA;
        break;
      end
    end
    busA.CYC_I = 1'b0;
    busA.STB_I = 1'b0;
  endtask

  // Random/model-checked access on dutA, including the one-cycle ACK width.
  task automatic runChecked(input logic we, input logic [15:0] adr,
                            input logic [3:0] sel, input logic [31:0] dat,
                            input string tag);
    logic expErr;
    expErr = isErr(adr, sel);
    applyStimulus(we, adr, sel, dat, lat, gotAck, gotErr);
    modelApply(we, adr, sel, dat);
    checkOutput({tag, " latency"}, 32'(lat), 32'd2);
    checkOutput({tag, " ack"}, 32'(gotAck), 32'(!expErr));
`ifdef SIMSRAM_ERRCHK_EN
    checkOutput({tag, " err"}, 32'(gotErr), 32'(expErr));
`endif
    checkOutput({tag, " DAT_O"}, busA.DAT_O, refDat);
    @(posedge clk); #1;
    checkOutput({tag, " ack width"}, 32'(busA.ACK_O), 32'd0);
  endtask

  initial begin
    int ackCount;
    int ackEdges[$];
    int e0, e1, e2;
    logic        rwe;
    logic [15:0] radr;

    vecs[0]  = '{1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 16'h0010, 4'hF, 32'h00000000, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 16'h0005, 4'hF, 32'h11223344, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 16'h0005, 4'h5, 32'hAABBCCDD, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 16'h0005, 4'hF, 32'h00000000, 1'b1, 1'b0, 32'h11BB33DD};
    vecs[5]  = '{1'b1, 16'h0007, 4'hF, 32'h00000000, 1'b1, 1'b0, 32'h11BB33DD};
    vecs[6]  = '{1'b0, 16'h0007, 4'hF, 32'h00000000, 1'b1, 1'b0, 32'h00000000};
    vecs[7]  = '{1'b1, 16'h00FF, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 32'h00000000};
    vecs[8]  = '{1'b0, 16'h00FF, 4'hF, 32'h00000000, 1'b1, 1'b0, 32'hCAFEF00D};
    vecs[9]  = '{1'b1, 16'h0000, 4'hF, 32'h0BADF00D, 1'b1, 1'b0, 32'hCAFEF00D};
    vecs[10] = '{1'b0, 16'h0100, 4'hF, 32'h00000000, !ERRMODE, ERRMODE,
                 ERRMODE ? 32'hCAFEF00D : 32'h00000000};
    vecs[11] = '{1'b1, 16'h0100, 4'hF, 32'h12345678, !ERRMODE, ERRMODE,
                 ERRMODE ? 32'hCAFEF00D : 32'h00000000};
    vecs[12] = '{1'b1, 16'h0010, 4'h0, 32'hFFFFFFFF, !ERRMODE, ERRMODE,
                 ERRMODE ? 32'hCAFEF00D : 32'h00000000};
    vecs[13] = '{1'b0, 16'h0000, 4'hF, 32'h00000000, 1'b1, 1'b0, 32'h0BADF00D};
    vecs[14] = '{1'b0, 16'h0010, 4'hF, 32'h00000000, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[15] = '{1'b0, 16'h00FF, 4'hF, 32'h00000000, 1'b1, 1'b0, 32'hCAFEF00D};

    for (int i = 0; i < 256; i++) refMem[i] = 32'd0;
    refDat = 32'd0;

    busA.CYC_I = 1'b0; busA.STB_I = 1'b0; busA.WE_I = 1'b0;
    busA.ADR_I = '0;   busA.SEL_I = '0;   busA.DAT_I = '0;
    busB.CYC_I = 1'b0; busB.STB_I = 1'b0; busB.WE_I = 1'b0;
    busB.ADR_I = '0;   busB.SEL_I = '0;   busB.DAT_I = '0;

    // Power-up reset.
    rst = 1'b1;
    #1;
    checkOutput("reset ACK_O", 32'(busA.ACK_O), 32'd0);
    checkOutput("reset DAT_O", busA.DAT_O, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Vector table on the 1-wait-state instance.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat,
                    lat, gotAck, gotErr);
      modelApply(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
      checkOutput($sformatf("vec%0d ack", i), 32'(gotAck), 32'(vecs[i].expAck));
`ifdef SIMSRAM_ERRCHK_EN
      checkOutput($sformatf("vec%0d err", i), 32'(gotErr), 32'(vecs[i].expErr));
`endif
      checkOutput($sformatf("vec%0d DAT_O", i), busA.DAT_O, vecs[i].expDat);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d ack width", i), 32'(busA.ACK_O), 32'd0);
    end

    // Reset between edges during the WAIT of a write to adr 5.
    busA.CYC_I = 1'b1; busA.STB_I = 1'b1; busA.WE_I = 1'b1;
    busA.ADR_I = 16'h0005; busA.SEL_I = 4'hF; busA.DAT_I = 32'h0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    checkOutput("midwait reset ACK_O", 32'(busA.ACK_O), 32'd0);
    checkOutput("midwait reset DAT_O", busA.DAT_O, 32'd0);
    busA.CYC_I = 1'b0; busA.STB_I = 1'b0;
    #1 rst = 1'b0;
    refDat = 32'd0;
    runChecked(1'b0, 16'h0005, 4'hF, 32'h0, "post-reset read");

    // Reset landing inside the ACK cycle clears ACK_O and DAT_O at once.
    busA.CYC_I = 1'b1; busA.STB_I = 1'b1; busA.WE_I = 1'b0;
    busA.ADR_I = 16'h0010; busA.SEL_I = 4'hF;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("pre-reset ACK_O", 32'(busA.ACK_O), 32'd1);
    checkOutput("pre-reset DAT_O", busA.DAT_O, 32'hDEADBEEF);
    #1 rst = 1'b1;
    #1;
    checkOutput("ack-cycle reset ACK_O", 32'(busA.ACK_O), 32'd0);
    checkOutput("ack-cycle reset DAT_O", busA.DAT_O, 32'd0);
    busA.CYC_I = 1'b0; busA.STB_I = 1'b0;
    #1 rst = 1'b0;
    refDat = 32'd0;
    runChecked(1'b0, 16'h0010, 4'hF, 32'h0, "after ack reset");

    // CYC_I dropped during WAIT, then during DONE, of writes to adr 7.
    for (int phase = 1; phase <= 2; phase++) begin
      busA.CYC_I = 1'b1; busA.STB_I = 1'b1; busA.WE_I = 1'b1;
      busA.ADR_I = 16'h0007; busA.SEL_I = 4'hF; busA.DAT_I = 32'hFFFFFFFF;
      repeat (phase) begin
        @(posedge clk); #1;
      end
      busA.CYC_I = 1'b0; busA.STB_I = 1'b0;
      ackCount = 0;
      repeat (4) begin
        @(posedge clk); #1;
        if (busA.ACK_O) ackCount++;
      end
      checkOutput($sformatf("abort%0d no ack", phase), 32'(ackCount), 32'd0);
      runChecked(1'b0, 16'h0007, 4'hF, 32'h0, $sformatf("abort%0d readback", phase));
    end

    // 3-wait-state instance: one write, then three reads with STB held.
    busB.CYC_I = 1'b1; busB.STB_I = 1'b1; busB.WE_I = 1'b1;
    busB.ADR_I = 8'd3; busB.SEL_I = 4'hF; busB.DAT_I = 32'hA5A50F0F;
    @(posedge clk); #1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (busB.ACK_O) begin
        lat = n;
        break;
      end
    end
    busB.CYC_I = 1'b0; busB.STB_I = 1'b0; busB.WE_I = 1'b0;
    checkOutput("B write latency", 32'(lat), 32'd4);
    @(posedge clk); #1;
    busB.CYC_I = 1'b1; busB.STB_I = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (busB.ACK_O) begin
        ackEdges.push_back(n);
        checkOutput("B burst DAT_O", busB.DAT_O, 32'hA5A50F0F);
        if (ackEdges.size() == 3) begin
          busB.CYC_I = 1'b0;
          busB.STB_I = 1'b0;
        end
      end
      if (ackEdges.size() == 3 && n >= ackEdges[2] + 2) break;
    end
    e0 = (ackEdges.size() > 0) ? ackEdges[0] : -1;
    e1 = (ackEdges.size() > 1) ? ackEdges[1] : -1;
    e2 = (ackEdges.size() > 2) ? ackEdges[2] : -1;
    checkOutput("B ack count", 32'(ackEdges.size()), 32'd3);
    checkOutput("B first ack edge", 32'(e0), 32'd4);
    checkOutput("B ack spacing 1", 32'(e1 - e0), 32'd5);
    checkOutput("B ack spacing 2", 32'(e2 - e1), 32'd5);

    // Random traffic on the 1-wait-state instance against the model.
    for (int a = 0; a < 16; a++) begin
      runChecked(1'b1, 16'(a), 4'hF, $urandom, $sformatf("init%0d", a));
    end
    for (int i = 0; i < 60; i++) begin
      rwe  = 1'($urandom_range(0, 1));
      radr = ($urandom_range(0, 9) == 0) ? 16'(256 + $urandom_range(0, 65279))
                                         : 16'($urandom_range(0, 15));
      runChecked(rwe, radr, 4'($urandom_range(0, 15)), $urandom,
                 $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
